uart_rx_buffer: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. It completes the receiver's four-phase req/ack handshake and stores each received byte in a synchronous FIFO of depth DEPTH. Bytes are presented to the host or bus side as a first-word-fall-through valid/ready stream. It reports fill level and a sticky overrun flag, which is set when the FIFO is full and a byte has to wait.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_rx_buffer.sv | 108 ++++++++++
 tb/tb_uart_rx_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: character width, receive handshake states and
// a helper for sizing FIFO fill-level counters.
package uart_pkg;

  localparam int unsigned UART_DATA_SIZE = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } hs_state_e;

  // A level counter must represent 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered pointers and level.
// Writes while full and reads while empty are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE = UART_DATA_SIZE,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [DATA_SIZE-1:0]        wr_data,
  input  logic                        rd_en,
  output logic [DATA_SIZE-1:0]        rd_data,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = level_w(DEPTH);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 do_wr, do_rd;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(do_wr);
    rd_ptr_d = rd_ptr_q + ADDR_W'(do_rd);
    level_d  = level_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; contents are only visible once level says so.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer: completes the receiver's four-phase req/ack handshake,
// queues bytes in a FIFO and presents them as a valid/ready stream.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE = UART_DATA_SIZE,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] recv_data,
  input  logic                 recv_req,
  output logic                 recv_ack,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADDR_W:0]      level,
  output logic                 full,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  hs_state_e state_q, state_d;
  logic      ack_q, ack_d;
  logic      overrun_q, overrun_d;
  logic      wr_en;
  logic      set_ovr;
  logic      empty;

  uart_sync_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (recv_data),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign rd_valid = !empty;
  assign recv_ack = ack_q;
  assign overrun  = overrun_q;

  // Writes gate on the registered full, so space freed by a read is only
  // usable from the following edge.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    wr_en   = 1'b0;
    set_ovr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (recv_req) begin
          if (!full) begin
            wr_en   = 1'b1;
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            set_ovr = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!recv_req) begin
          state_d = S_IDLE;
        end else if (!full) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!recv_req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (set_ovr)     overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: transaction-level queue model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] recv_data = '0;
  logic          recv_req = 1'b0;
  logic          recv_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [AW:0]   level;
  logic          full;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        rnd = 1'b0;

  uart_rx_buffer #(
    .DATA_SIZE (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .recv_data   (recv_data),
    .recv_req    (recv_req),
    .recv_ack    (recv_ack),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .level       (level),
    .full        (full),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the stored bytes as a queue, plus whether the current request has
  // been acknowledged or is parked waiting for space.
  logic [DW-1:0] mq[$];
  bit            m_acked, m_waiting, m_ovr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_acked = 0; m_waiting = 0; m_ovr = 0;
    end else begin
      automatic bit was_full = (mq.size() == DEPTH);
      automatic bit pop      = rd_ready && (mq.size() != 0);
      automatic bit set      = 0;
      if (m_acked) begin
        if (!recv_req) m_acked = 0;
      end else if (recv_req && !was_full) begin
        mq.push_back(recv_data);
        m_acked = 1; m_waiting = 0;
      end else if (recv_req && !m_waiting) begin
        m_waiting = 1; set = 1;
      end else if (!recv_req) begin
        m_waiting = 0;
      end
      if (pop) void'(mq.pop_front());
      if (overrun_clr) m_ovr = 0;
      if (set) m_ovr = 1;
    end
  end

  always @(negedge clk) begin
    check("m_ack",     32'(recv_ack), 32'(m_acked));
    check("m_valid",   32'(rd_valid), 32'(mq.size() != 0));
    check("m_level",   32'(level),    32'(mq.size()));
    check("m_full",    32'(full),     32'(mq.size() == DEPTH));
    check("m_overrun", 32'(overrun),  32'(m_ovr));
    if (mq.size() != 0) check("m_rd_data", 32'(rd_data), 32'(mq[0]));
  end

  always begin
    @(posedge clk); #2;
    if (rnd) begin
      rd_ready    = ($urandom_range(0, 2) == 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic handshake(input logic [DW-1:0] b);
    int unsigned n;
    recv_data = b; recv_req = 1'b1; n = 0;
    do begin tick(); n++; end while (!recv_ack && n < 40);
    check("hs_ack_rise", 32'(recv_ack), 32'd1);
    recv_req = 1'b0; n = 0;
    do begin tick(); n++; end while (recv_ack && n < 40);
    check("hs_ack_fall", 32'(recv_ack), 32'd0);
  endtask

  task automatic drain(input int unsigned cnt, input logic [DW-1:0] first);
    rd_ready = 1'b1;
    for (int unsigned i = 0; i < cnt; i++) begin
      check("drain_data", 32'(rd_data), 32'(first + DW'(i)));
      tick();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    // 1: reset, single byte
    tick(); tick();
    check("rst_ack", 32'(recv_ack), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    recv_data = 8'hA5; recv_req = 1'b1;
    tick();
    check("t1_ack", 32'(recv_ack), 32'd1);
    check("t1_valid", 32'(rd_valid), 32'd1);
    check("t1_data", 32'(rd_data), 32'hA5);
    check("t1_level", 32'(level), 32'd1);
    recv_req = 1'b0;
    tick();
    check("t1_ack_drop", 32'(recv_ack), 32'd0);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("t1_valid_after_rd", 32'(rd_valid), 32'd0);
    check("t1_level_after_rd", 32'(level), 32'd0);

    // 2: fill, overrun, space frees one edge after read
    for (int unsigned i = 0; i < DEPTH; i++) handshake(DW'(i));
    check("t2_full", 32'(full), 32'd1);
    check("t2_level", 32'(level), 32'd16);
    recv_data = 8'h10; recv_req = 1'b1;
    tick(); tick(); tick();
    check("t2_no_ack", 32'(recv_ack), 32'd0);
    check("t2_overrun", 32'(overrun), 32'd1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("t2_ack_not_yet", 32'(recv_ack), 32'd0);
    tick();
    check("t2_ack_late", 32'(recv_ack), 32'd1);
    check("t2_level_refill", 32'(level), 32'd16);
    recv_req = 1'b0; tick();
    drain(DEPTH, 8'h01);
    check("t2_empty", 32'(level), 32'd0);

    // 3: simultaneous read and write at level 5
    for (int unsigned i = 0; i < 5; i++) handshake(8'h20 + DW'(i));
    recv_data = 8'h25; recv_req = 1'b1; rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("t3_ack", 32'(recv_ack), 32'd1);
    check("t3_level", 32'(level), 32'd5);
    check("t3_head", 32'(rd_data), 32'h21);
    recv_req = 1'b0; tick();
    drain(5, 8'h21);

    // 4: request withdrawn while waiting on full
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check("t4_pre_clr", 32'(overrun), 32'd0);
    for (int unsigned i = 0; i < DEPTH; i++) handshake(8'h30 + DW'(i));
    recv_data = 8'h77; recv_req = 1'b1;
    tick(); tick(); tick();
    recv_req = 1'b0; tick();
    check("t4_no_ack", 32'(recv_ack), 32'd0);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_level", 32'(level), 32'd16);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check("t4_clr", 32'(overrun), 32'd0);

    // 6: set and clear in the same cycle, set wins
    recv_data = 8'h78; recv_req = 1'b1; overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t6_set_wins", 32'(overrun), 32'd1);
    recv_req = 1'b0; tick();
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check("t6_clr", 32'(overrun), 32'd0);
    drain(DEPTH, 8'h30);
    check("t6_empty", 32'(level), 32'd0);

    // 5: asynchronous reset mid-handshake
    handshake(8'h51); handshake(8'h52);
    recv_data = 8'h53; recv_req = 1'b1;
    tick();
    check("t5_ack", 32'(recv_ack), 32'd1);
    check("t5_level", 32'(level), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("t5_async_ack", 32'(recv_ack), 32'd0);
    check("t5_async_level", 32'(level), 32'd0);
    check("t5_async_valid", 32'(rd_valid), 32'd0);
    recv_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    handshake(8'h54);
    check("t5_after_level", 32'(level), 32'd1);
    check("t5_after_data", 32'(rd_data), 32'h54);
    drain(1, 8'h54);

    // Random traffic against the model
    rnd = 1'b1;
    for (int unsigned t = 0; t < 120; t++) begin
      int unsigned gap, lim, n;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      recv_data = DW'($urandom);
      recv_req = 1'b1;
      lim = $urandom_range(1, 8); n = 0;
      do begin tick(); n++; end while (!recv_ack && n < lim);
      recv_req = 1'b0;
      if (recv_ack) begin
        n = 0;
        do begin tick(); n++; end while (recv_ack && n < 40);
        check("rnd_ack_fall", 32'(recv_ack), 32'd0);
      end else begin
        tick();
      end
    end
    rnd = 1'b0;
    tick();
    rd_ready = 1'b0; overrun_clr = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
